// File: rtl/seq_gate_arbiter.sv
// Two requesters share one gate unit through a round-robin arbiter; results
// land in a 2-entry queue tagged with the requester id and drain via val/rdy.
module seq_gate_arbiter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_val,
  output logic         req0_rdy,
  input  logic [W-1:0] req0_in0,
  input  logic [W-1:0] req0_in1,
  input  logic [1:0]   req0_op,
  input  logic         req1_val,
  output logic         req1_rdy,
  input  logic [W-1:0] req1_in0,
  input  logic [W-1:0] req1_in1,
  input  logic [1:0]   req1_op,
  output logic         resp_val,
  input  logic         resp_rdy,
  output logic [W-1:0] resp_out,
  output logic         resp_id
);

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } entry_t;

  function automatic logic [W-1:0] apply_op(input op_e op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       prio_q, prio_d;
  entry_t     mem_q [2];
  entry_t     mem_d [2];

  logic   can_acc;
  logic   fire;
  logic   grant_id;
  logic   deq;
  entry_t new_entry;
  entry_t head;

  // Acceptance looks only at occupancy, never at resp_rdy, so no
  // combinational path exists from the consumer back to the requesters.
  always_comb begin
    can_acc  = (count_q < 2'd2);
    fire     = can_acc & (req0_val | req1_val);
    grant_id = (req0_val & req1_val) ? prio_q : req1_val;
    req0_rdy = fire & ~grant_id;
    req1_rdy = fire & grant_id;
    deq      = (count_q != 2'd0) & resp_rdy;

    new_entry.id   = grant_id;
    new_entry.data = grant_id ? apply_op(op_e'(req1_op), req1_in0, req1_in1)
                              : apply_op(op_e'(req0_op), req0_in0, req0_in1);
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    prio_d   = prio_q;
    for (int i = 0; i < 2; i++) mem_d[i] = mem_q[i];

    if (fire) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = ~wr_ptr_q;
      prio_d          = ~grant_id;
    end
    if (deq) rd_ptr_d = ~rd_ptr_q;

    case ({fire, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      prio_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      prio_q   <= prio_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; an entry is only observable
  // while count says it is valid, and the outputs are gated below.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) mem_q[i] <= mem_d[i];
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    resp_val = (count_q != 2'd0);
    resp_out = resp_val ? head.data : '0;
    resp_id  = resp_val ? head.id : 1'b0;
  end

endmodule

// File: tb/tb_seq_gate_arbiter.sv
// Scoreboard bench for seq_gate_arbiter: a queue-level reference model predicts
// grants and results; a separate monitor compares every presented response.
module tb_seq_gate_arbiter;
  localparam int W = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_val, req0_rdy;
  logic [W-1:0] req0_in0, req0_in1;
  logic [1:0]   req0_op;
  logic         req1_val, req1_rdy;
  logic [W-1:0] req1_in0, req1_in1;
  logic [1:0]   req1_op;
  logic         resp_val, resp_rdy;
  logic [W-1:0] resp_out;
  logic         resp_id;

  always #5 clk = ~clk;

  seq_gate_arbiter #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0_val (req0_val),
    .req0_rdy (req0_rdy),
    .req0_in0 (req0_in0),
    .req0_in1 (req0_in1),
    .req0_op  (req0_op),
    .req1_val (req1_val),
    .req1_rdy (req1_rdy),
    .req1_in0 (req1_in0),
    .req1_in1 (req1_in1),
    .req1_op  (req1_op),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_out (resp_out),
    .resp_id  (resp_id)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: queue occupancy and whose turn it is on a tie.
  int   model_cnt  = 0;
  logic model_prio = 1'b0;

  logic         last_rdy0, last_rdy1, last_resp_val;
  logic [W-1:0] last_resp_out;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gate(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // One clock cycle: drive inputs, predict handshakes from the model, then
  // advance the model the way the queue should advance at the next edge.
  task automatic step(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [1:0] o0, input logic v1, input logic [W-1:0] a1,
                      input logic [W-1:0] b1, input logic [1:0] o1, input logic rr);
    logic can, e0, e1, fired, popped;
    exp_t item;
    req0_val = v0; req0_in0 = a0; req0_in1 = b0; req0_op = o0;
    req1_val = v1; req1_in0 = a1; req1_in1 = b1; req1_op = o1;
    resp_rdy = rr;
    @(negedge clk);
    #1;
    last_rdy0     = req0_rdy;
    last_rdy1     = req1_rdy;
    last_resp_val = resp_val;
    last_resp_out = resp_out;

    can = (model_cnt < 2);
    e0  = can && v0 && (!v1 || model_prio == 1'b0);
    e1  = can && v1 && (!v0 || model_prio == 1'b1);
    check("req0_rdy", 32'(req0_rdy), 32'(e0));
    check("req1_rdy", 32'(req1_rdy), 32'(e1));
    check("resp_val", 32'(resp_val), (model_cnt != 0) ? 1 : 0);

    fired  = e0 || e1;
    popped = (model_cnt != 0) && rr;
    if (e0) begin
      item.id = 1'b0; item.data = gate(o0, a0, b0); sb_q.push_back(item);
    end
    if (e1) begin
      item.id = 1'b1; item.data = gate(o1, a1, b1); sb_q.push_back(item);
    end
    if (fired) model_prio = e0 ? 1'b1 : 1'b0;
    model_cnt = model_cnt + (fired ? 1 : 0) - (popped ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0, rr);
  endtask

  task automatic both(input logic rr);
    step(1'b1, W'(1), W'(0), 2'd2, 1'b1, W'(1), W'(1), 2'd0, rr);
  endtask

  // Assert reset off the clock edge; outputs must clear asynchronously.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_resp_val", 32'(resp_val), 0);
    check("rst_resp_out", 32'(resp_out), 0);
    check("rst_resp_id", 32'(resp_id), 0);
    sb_q.delete();
    model_cnt  = 0;
    model_prio = 1'b0;
    req0_val = 1'b0; req1_val = 1'b0; resp_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever the DUT presents a response, its head must match the
  // oldest outstanding expectation; a consumed head is retired.
  always @(negedge clk) begin
    if (reset && resp_val) begin
      if (sb_q.size() == 0) begin
        check("resp_unexpected", 1, 0);
      end else begin
        check("resp_out", 32'(resp_out), 32'(sb_q[0].data));
        check("resp_id", 32'(resp_id), 32'(sb_q[0].id));
        if (resp_rdy) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req0_val = 1'b0; req0_in0 = '0; req0_in1 = '0; req0_op = 2'd0;
    req1_val = 1'b0; req1_in0 = '0; req1_in1 = '0; req1_op = 2'd0;
    resp_rdy = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single requester: NAND of 1,1 gives 0 from requester 0.
    step(1'b1, W'(1), W'(1), 2'd3, 1'b0, '0, '0, 2'd0, 1'b0);
    idle(1'b1);
    check("single_val", 32'(last_resp_val), 1);
    check("single_out", 32'(last_resp_out), 0);
    // Requester 1 alone hands the tie-break back to requester 0.
    step(1'b0, '0, '0, 2'd0, 1'b1, W'(1), W'(0), 2'd1, 1'b1);

    // Fairness: both valid for four cycles alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      both(1'b1);
      check("fair_grant0", 32'(last_rdy0), (k % 2 == 0) ? 1 : 0);
      check("fair_grant1", 32'(last_rdy1), (k % 2 == 1) ? 1 : 0);
    end
    idle(1'b1);

    // Full: two accepts with a stalled consumer, then both rdy drop.
    both(1'b0);
    both(1'b0);
    both(1'b0);
    check("full_rdy0", 32'(last_rdy0), 0);
    check("full_rdy1", 32'(last_rdy1), 0);
    both(1'b0);

    // Drain one, then enqueue XOR 1^0 while the remaining head leaves.
    idle(1'b1);
    step(1'b1, W'(1), W'(0), 2'd2, 1'b0, '0, '0, 2'd0, 1'b1);
    check("enqdeq_rdy0", 32'(last_rdy0), 1);
    idle(1'b0);
    check("enqdeq_val", 32'(last_resp_val), 1);
    check("enqdeq_head", 32'(last_resp_out), 1);

    // Fill to two entries, then reset mid-stream.
    both(1'b0);
    both(1'b0);
    do_reset();
    both(1'b0);
    check("post_rst_rdy0", 32'(last_rdy0), 1);
    check("post_rst_rdy1", 32'(last_rdy1), 0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 2'($urandom),
           1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 2'($urandom),
           1'($urandom_range(0, 3) != 0));
    end
    repeat (3) idle(1'b1);
    check("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
